// File: rtl/shift_right_unit_negedge.sv
// Falling-edge right-shift engine: loads a word and count, then shifts one bit per
// falling edge onto serial_out. Optional arithmetic fill enabled by SHIFTR_ARITH_EN.
module shift_right_unit_negedge #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] D,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
`ifdef SHIFTR_ARITH_EN
  input  logic             arith,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] clamped;
  logic             accept;
  logic             fill;

  assign clamped = (amount > WIDTH_CNT) ? WIDTH_CNT : amount;
  assign accept  = (state == IDLE) && load_valid;

`ifdef SHIFTR_ARITH_EN
  logic arith_q;

  // Sign fill replicates the current MSB; serial_in is ignored in that mode.
  assign fill = arith_q ? Q[WIDTH-1] : serial_in;

  always_ff @(negedge clock) begin
    if (reset) begin
      arith_q <= 1'b0;
    end else if (accept) begin
      arith_q <= arith;
    end
  end
`else
  assign fill = serial_in;
`endif

  always_ff @(negedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          next_state = (clamped == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (remaining == CNT_W'(1)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // serial_valid is only ever set by a shift edge, so it drops on every other edge.
  always_ff @(negedge clock) begin
    if (reset) begin
      Q            <= '0;
      remaining    <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
    end else if (accept) begin
      Q            <= D;
      remaining    <= clamped;
      serial_valid <= 1'b0;
    end else if (state == SHIFT) begin
      Q            <= {fill, Q[WIDTH-1:1]};
      serial_out   <= Q[0];
      serial_valid <= 1'b1;
      remaining    <= remaining - CNT_W'(1);
    end else begin
      serial_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_right_unit_negedge.sv
// Self-checking bench for shift_right_unit_negedge: directed table, reset corner
// cases and randomized transactions against a value-level reference model.
module tb_shift_right_unit_negedge;

  localparam int WIDTH = 128;
  localparam int CNT_W = 8;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic             clock;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] D;
  logic [CNT_W-1:0] amount;
  logic             serial_in;
  logic             arith;
  logic [WIDTH-1:0] Q;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;

  int checks;
  int failures;

  shift_right_unit_negedge #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .D            (D),
    .amount       (amount),
    .serial_in    (serial_in),
`ifdef SHIFTR_ARITH_EN
    .arith        (arith),
`endif
    .Q            (Q),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [WIDTH-1:0] d;
    int               amt;
    int               sinMode;
    bit               holdValid;
    logic [WIDTH-1:0] expQ;
  } vec_t;

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic pickSerial(input int sinMode);
    if (sinMode == 0) return 1'b0;
    if (sinMode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one full load/shift/done transaction, checking every edge against the model.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input int amt, input int sinMode,
                               input bit holdValid, input bit arithBit,
                               output logic [WIDTH-1:0] finalQ);
    logic [WIDTH-1:0] model;
    logic             fillBit;
    int               n;
    n = (amt > WIDTH) ? WIDTH : amt;
    load_valid = 1'b1;
    D          = d;
    amount     = CNT_W'(amt);
    arith      = arithBit;
    serial_in  = pickSerial(sinMode);
    step();
    model = d;
    checkOutput("accept_q", Q, model);
    checkOutput("accept_valid", {127'b0, serial_valid}, 128'd0);
    checkOutput("accept_ready", {127'b0, load_ready}, 128'd0);
    checkOutput("accept_done", {127'b0, done}, {127'b0, n == 0});
    if (holdValid) begin
      D      = ~d;
      amount = CNT_W'($urandom_range(1, 255));
      arith  = ~arithBit;
    end else begin
      load_valid = 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      serial_in = pickSerial(sinMode);
      fillBit   = arithBit ? model[WIDTH-1] : serial_in;
      step();
      model = (model >> 1) | (fillBit ? MSB_MASK : '0);
      checkOutput("shift_q", Q, model);
      checkOutput("shift_out", {127'b0, serial_out}, {127'b0, d[k-1]});
      checkOutput("shift_valid", {127'b0, serial_valid}, 128'd1);
      checkOutput("shift_done", {127'b0, done}, {127'b0, k == n});
      checkOutput("shift_busy", {127'b0, busy}, 128'd1);
    end
    load_valid = 1'b0;
    step();
    checkOutput("end_q", Q, model);
    checkOutput("end_valid", {127'b0, serial_valid}, 128'd0);
    checkOutput("end_done", {127'b0, done}, 128'd0);
    checkOutput("end_busy", {127'b0, busy}, 128'd0);
    checkOutput("end_ready", {127'b0, load_ready}, 128'd1);
    finalQ = Q;
  endtask

  initial begin
    vec_t             vecs[$];
    logic [WIDTH-1:0] finalQ;
    logic [WIDTH-1:0] heldQ;
    logic [WIDTH-1:0] rd;
    int               ramt;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    load_valid = 1'b0;
    D          = '0;
    amount     = '0;
    serial_in  = 1'b0;
    arith      = 1'b0;

    vecs.push_back('{128'hF5, 4, 0, 1'b0, 128'hF});
    vecs.push_back('{128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 0, 1, 1'b1,
                     128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321});
    vecs.push_back('{128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 200, 0, 1'b0, 128'h0});
    vecs.push_back('{128'h0, 8, 1, 1'b1, {8'hFF, 120'h0}});
    vecs.push_back('{{64{2'b10}}, 128, 1, 1'b0, {128{1'b1}}});
    vecs.push_back('{{1'b1, 127'h0}, 1, 0, 1'b0, {2'b01, 126'h0}});
    vecs.push_back('{{1'b1, 127'h0}, 127, 0, 1'b1, 128'h1});
    vecs.push_back('{128'hDEAD_BEEF, 129, 0, 1'b0, 128'h0});

    step();
    step();
    checkOutput("reset_q", Q, 128'd0);
    checkOutput("reset_ready", {127'b0, load_ready}, 128'd1);
    checkOutput("reset_busy", {127'b0, busy}, 128'd0);
    checkOutput("reset_done", {127'b0, done}, 128'd0);
    checkOutput("reset_valid", {127'b0, serial_valid}, 128'd0);

    // Reset must win over a simultaneous load request.
    load_valid = 1'b1;
    D          = 128'hABCD;
    amount     = 8'd3;
    step();
    checkOutput("reset_prio_q", Q, 128'd0);
    checkOutput("reset_prio_busy", {127'b0, busy}, 128'd0);
    load_valid = 1'b0;
    reset      = 1'b0;
    step();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].d, vecs[i].amt, vecs[i].sinMode, vecs[i].holdValid, 1'b0, finalQ);
      checkOutput("table_final_q", finalQ, vecs[i].expQ);
    end

    // Reset at the third of ten shifts aborts without a done pulse.
    load_valid = 1'b1;
    D          = 128'h0123_4567_89AB_CDEF;
    amount     = 8'd10;
    serial_in  = 1'b0;
    step();
    load_valid = 1'b0;
    step();
    step();
    heldQ = Q;
    @(posedge clock);
    #1;
    checkOutput("posedge_no_effect", Q, heldQ);
    checkOutput("mid_q", heldQ, 128'h0123_4567_89AB_CDEF >> 2);
    reset = 1'b1;
    step();
    checkOutput("midrst_q", Q, 128'd0);
    checkOutput("midrst_busy", {127'b0, busy}, 128'd0);
    checkOutput("midrst_valid", {127'b0, serial_valid}, 128'd0);
    checkOutput("midrst_ready", {127'b0, load_ready}, 128'd1);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("midrst_no_done", {127'b0, done}, 128'd0);
    end
    applyStimulus(128'hF0F0, 5, 0, 1'b0, 1'b0, finalQ);
    checkOutput("post_rst_final", finalQ, 128'h0787);

`ifdef SHIFTR_ARITH_EN
    applyStimulus({1'b1, 127'h0}, 4, 0, 1'b0, 1'b1, finalQ);
    checkOutput("arith_one", finalQ, {8'hF8, 120'h0});
    applyStimulus({1'b1, 127'h0}, 4, 0, 1'b0, 1'b0, finalQ);
    checkOutput("arith_zero", finalQ, {8'h08, 120'h0});
`endif

    for (int t = 0; t < 24; t++) begin
      rd   = {$urandom, $urandom, $urandom, $urandom};
      ramt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
`ifdef SHIFTR_ARITH_EN
      applyStimulus(rd, ramt, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), finalQ);
`else
      applyStimulus(rd, ramt, 2, 1'($urandom_range(0, 1)), 1'b0, finalQ);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
